// File: rtl/flash_pkg.sv
// Shared definitions for the flash word fetcher: address width, FSM states
// and the word-alignment helper.
package flash_pkg;

    localparam int FLASH_ADDR_W = 24;
    localparam logic [7:0] FLASH_READ_CMD = 8'h03;
    localparam int WORD_BYTES = 4;
    localparam int TAG_W = FLASH_ADDR_W - 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_RESP
    } state_t;

    function automatic logic [FLASH_ADDR_W-1:0] word_base(input logic [FLASH_ADDR_W-1:0] addr);
        return {addr[FLASH_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/flash_word_fetcher_if.sv
// Processor-side request/response bus plus the byte-read link to the
// SPI flash controller, bundled for the fetcher.
interface flash_word_fetcher_if;
    import flash_pkg::*;

    logic                    req_valid;
    logic [FLASH_ADDR_W-1:0] req_addr;
    logic                    req_ready;
    logic                    inv;
    logic                    rsp_valid;
    logic [31:0]             rsp_data;
    logic                    rsp_err;
    logic                    fl_chipSel;
    logic                    fl_readMem;
    logic [FLASH_ADDR_W-1:0] fl_addr;
    logic [7:0]              fl_data;
    logic                    fl_ready;

    // master: processor plus controller side; slave: the fetcher itself
    modport master (
        output req_valid, req_addr, inv, fl_data, fl_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err, fl_chipSel, fl_readMem, fl_addr
    );

    modport slave (
        input  req_valid, req_addr, inv, fl_data, fl_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err, fl_chipSel, fl_readMem, fl_addr
    );

endinterface

// File: rtl/flash_word_buf.sv
// One-entry word buffer: tag/valid/data register with combinational lookup.
// An invalidate in the same cycle as a write leaves the entry invalid.
module flash_word_buf
    import flash_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data,
    input  logic             inv
);

    logic             valid_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [31:0]      data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
            data_reg  <= '0;
        end else begin
            if (wr_en) begin
                tag_reg  <= wr_tag;
                data_reg <= wr_data;
            end
            if (inv) begin
                valid_reg <= 1'b0;
            end else if (wr_en) begin
                valid_reg <= 1'b1;
            end
        end
    end

    // a concurrent invalidate must force a miss in the lookup cycle
    assign hit     = valid_reg && (tag_reg == lookup_tag) && !inv;
    assign rd_data = data_reg;

endmodule

// File: rtl/flash_word_fetcher.sv
// Turns 32-bit word reads into four single-byte reads on the flash controller,
// assembles them little-endian, caches the last word and times out stuck bytes.
module flash_word_fetcher
    import flash_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200,
    parameter bit BUF_EN      = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    flash_word_fetcher_if.slave bus
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    state_t                  state_reg, state_next;
    logic [FLASH_ADDR_W-1:0] base_reg, base_next;
    logic [1:0]              idx_reg, idx_next;
    logic [WD_W-1:0]         wdog_reg, wdog_next;
    logic [31:0]             word_reg, word_next;
    logic                    miss_reg, miss_next;
    logic                    req_ready_reg, req_ready_next;
    logic                    rsp_valid_reg, rsp_valid_next;
    logic [31:0]             rsp_data_reg, rsp_data_next;
    logic                    rsp_err_reg, rsp_err_next;
    logic                    cs_reg, cs_next;
    logic [FLASH_ADDR_W-1:0] fl_addr_reg, fl_addr_next;

    logic                    buf_hit;
    logic [31:0]             buf_rd;
    logic                    buf_wr;
    logic [31:0]             word_captured;

    // incoming byte lands in lane idx; other lanes keep what is already assembled
    genvar gi;
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
        assign word_captured[gi*8 +: 8] = (idx_reg == 2'(gi)) ? bus.fl_data : word_reg[gi*8 +: 8];
    end

    if (BUF_EN) begin : g_buf
        flash_word_buf u_buf (
            .clk        (clk),
            .rst        (rst),
            .lookup_tag (base_reg[FLASH_ADDR_W-1:2]),
            .hit        (buf_hit),
            .rd_data    (buf_rd),
            .wr_en      (buf_wr),
            .wr_tag     (base_reg[FLASH_ADDR_W-1:2]),
            .wr_data    (rsp_data_reg),
            .inv        (bus.inv)
        );
    end else begin : g_nobuf
        assign buf_hit = 1'b0;
        assign buf_rd  = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            base_reg      <= '0;
            idx_reg       <= '0;
            wdog_reg      <= '0;
            word_reg      <= '0;
            miss_reg      <= 1'b0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
            cs_reg        <= 1'b0;
            fl_addr_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            base_reg      <= base_next;
            idx_reg       <= idx_next;
            wdog_reg      <= wdog_next;
            word_reg      <= word_next;
            miss_reg      <= miss_next;
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_err_reg   <= rsp_err_next;
            cs_reg        <= cs_next;
            fl_addr_reg   <= fl_addr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        base_next      = base_reg;
        idx_next       = idx_reg;
        wdog_next      = wdog_reg;
        word_next      = word_reg;
        miss_next      = miss_reg;
        req_ready_next = 1'b0;
        rsp_valid_next = 1'b0;
        rsp_data_next  = rsp_data_reg;
        rsp_err_next   = 1'b0;
        cs_next        = cs_reg;
        fl_addr_next   = fl_addr_reg;
        buf_wr         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                req_ready_next = 1'b1;
                if (bus.req_valid) begin
                    base_next      = word_base(bus.req_addr);
                    idx_next       = 2'd0;
                    req_ready_next = 1'b0;
                    state_next     = ST_LOOKUP;
                end
            end

            ST_LOOKUP: begin
                if (buf_hit) begin
                    rsp_data_next  = buf_rd;
                    rsp_valid_next = 1'b1;
                    miss_next      = 1'b0;
                    state_next     = ST_RESP;
                end else begin
                    miss_next  = 1'b1;
                    state_next = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                cs_next      = 1'b1;
                fl_addr_next = base_reg + {{(FLASH_ADDR_W-2){1'b0}}, idx_reg};
                wdog_next    = '0;
                state_next   = ST_WAIT;
            end

            ST_WAIT: begin
                wdog_next = wdog_reg + 1'b1;
                if (bus.fl_ready) begin
                    cs_next   = 1'b0;
                    word_next = word_captured;
                    if (idx_reg == 2'd3) begin
                        rsp_data_next  = word_captured;
                        rsp_valid_next = 1'b1;
                        state_next     = ST_RESP;
                    end else begin
                        state_next = ST_GAP;
                    end
                end else if (wdog_reg == WD_W'(TIMEOUT_CYC - 1)) begin
                    // abandon the word; clearing miss keeps it out of the buffer
                    cs_next        = 1'b0;
                    rsp_err_next   = 1'b1;
                    rsp_valid_next = 1'b1;
                    miss_next      = 1'b0;
                    state_next     = ST_RESP;
                end
            end

            ST_GAP: begin
                idx_next   = idx_reg + 2'd1;
                state_next = ST_ISSUE;
            end

            ST_RESP: begin
                buf_wr         = miss_reg;
                req_ready_next = 1'b1;
                state_next     = ST_IDLE;
            end

            default: begin
                req_ready_next = 1'b1;
                cs_next        = 1'b0;
                state_next     = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready  = req_ready_reg;
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_data   = rsp_data_reg;
    assign bus.rsp_err    = rsp_err_reg;
    assign bus.fl_chipSel = cs_reg;
    assign bus.fl_readMem = cs_reg;
    assign bus.fl_addr    = fl_addr_reg;

endmodule

// File: tb/tb_flash_word_fetcher.sv
// Directed bench for flash_word_fetcher with a behavioural byte-read controller
// and a word-level model of the buffer and response stream.
module tb_flash_word_fetcher;

    localparam int TIMEOUT = 20;
    localparam int LAT     = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flash_word_fetcher_if dut_if ();

    flash_word_fetcher #(.TIMEOUT_CYC(TIMEOUT), .BUF_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_cnt = 0;

    bit stall = 0;
    int ctl_cnt = 0;
    bit ctl_armed = 1;

    bit          mv = 0;
    logic [21:0] mtag = '0;
    bit          pend_lookup = 0;
    bit          busy = 0;
    bit          cur_hit = 0;
    bit          exp_err = 0;
    logic [23:0] cur_base = '0;
    int          acc_cyc = 0;
    bit          rst_at_edge = 0;
    bit          tmo_flag = 0;

    bit          s_rsp_valid = 0;
    bit          s_rsp_err = 0;
    bit          s_cs_prev = 0;
    bit          s_ready_prev = 0;
    logic [23:0] s_addr_prev = '0;
    logic [31:0] held = '0;
    logic [23:0] addr_q[$];

    bit          lit_en = 0;
    bit          lit_hit = 0;
    bit          lit_err = 0;
    logic [31:0] lit_data = '0;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            24'hFFFFFC: return 8'hA1;
            24'hFFFFFD: return 8'hB2;
            24'hFFFFFE: return 8'hC3;
            24'hFFFFFF: return 8'hD4;
            default:    return a[7:0] ^ a[15:8] ^ 8'h5C;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] b);
        return {mem_byte(b + 24'd3), mem_byte(b + 24'd2), mem_byte(b + 24'd1), mem_byte(b)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // model update for the edge about to happen, from inputs as they stand now
    task automatic pre_edge();
        rst_at_edge = rst;
        if (rst) begin
            mv = 0;
            pend_lookup = 0;
            busy = 0;
            addr_q.delete();
        end else begin
            if (s_rsp_valid && !s_rsp_err && !cur_hit && !dut_if.inv) begin
                mv = 1;
                mtag = cur_base[23:2];
            end
            if (pend_lookup) begin
                cur_hit = mv && (mtag == cur_base[23:2]) && !dut_if.inv;
                pend_lookup = 0;
            end
            if (dut_if.inv) mv = 0;
            if (dut_if.req_valid && dut_if.req_ready) begin
                cur_base = {dut_if.req_addr[23:2], 2'b00};
                pend_lookup = 1;
                busy = 1;
                acc_cyc = cyc;
                exp_err = stall;
            end
        end
    endtask

    // behavioural controller: ready pulse with data on the LAT-th selected cycle
    task automatic ctrl_step();
        dut_if.fl_ready = 1'b0;
        dut_if.fl_data  = 8'h5A;
        if (!(dut_if.fl_chipSel && dut_if.fl_readMem)) begin
            ctl_cnt = 0;
            ctl_armed = 1;
        end else if (ctl_armed && !stall) begin
            ctl_cnt++;
            if (ctl_cnt == LAT) begin
                dut_if.fl_ready = 1'b1;
                dut_if.fl_data  = mem_byte(dut_if.fl_addr);
                ctl_armed = 0;
            end
        end
    endtask

    task automatic check_cycle();
        cyc++;
        if (tmo_flag) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout: no response within bound, required one (cycle %0d)", cyc);
            tmo_flag = 0;
        end
        if (rst_at_edge) begin
            chk("reset_req_ready", 32'(dut_if.req_ready), 32'd1);
            chk("reset_rsp_valid", 32'(dut_if.rsp_valid), 32'd0);
            chk("reset_rsp_err", 32'(dut_if.rsp_err), 32'd0);
            chk("reset_rsp_data", dut_if.rsp_data, 32'd0);
            chk("reset_chipsel", 32'(dut_if.fl_chipSel), 32'd0);
            chk("reset_readmem", 32'(dut_if.fl_readMem), 32'd0);
            chk("reset_fl_addr", 32'(dut_if.fl_addr), 32'd0);
            s_rsp_valid = 0; s_rsp_err = 0; s_cs_prev = 0; s_ready_prev = 0;
            held = '0;
            return;
        end
        chk("req_ready", 32'(dut_if.req_ready), 32'(!busy));
        chk("readmem_eq_cs", 32'(dut_if.fl_readMem), 32'(dut_if.fl_chipSel));
        if (s_ready_prev) chk("cs_drop_after_ready", 32'(dut_if.fl_chipSel), 32'd0);
        if (dut_if.fl_chipSel) begin
            chk("cs_only_when_busy", 32'(busy), 32'd1);
            chk("fl_addr_seq", 32'(dut_if.fl_addr), 32'(cur_base + 24'(addr_q.size())));
            if (s_cs_prev) chk("fl_addr_stable", 32'(dut_if.fl_addr), 32'(s_addr_prev));
        end
        if (!dut_if.rsp_valid) begin
            chk("rsp_data_held", dut_if.rsp_data, held);
            chk("rsp_err_idle", 32'(dut_if.rsp_err), 32'd0);
        end
        s_ready_prev = dut_if.fl_ready && dut_if.fl_chipSel;
        if (s_ready_prev) addr_q.push_back(dut_if.fl_addr);
        if (dut_if.rsp_valid) begin
            chk("rsp_while_busy", 32'(busy), 32'd1);
            chk("rsp_one_cycle", 32'(s_rsp_valid), 32'd0);
            chk("rsp_err", 32'(dut_if.rsp_err), 32'(exp_err));
            if (!exp_err) chk("rsp_data", dut_if.rsp_data, exp_word(cur_base));
            if (exp_err) begin
                chk("timeout_latency", 32'(cyc - acc_cyc), 32'(TIMEOUT + 3));
                chk("timeout_cs_low", 32'(dut_if.fl_chipSel), 32'd0);
                chk("timeout_bytes", 32'(addr_q.size()), 32'd0);
            end else if (cur_hit) begin
                chk("hit_latency", 32'(cyc - acc_cyc), 32'd2);
                chk("hit_no_flash", 32'(addr_q.size()), 32'd0);
            end else begin
                chk("miss_bytes", 32'(addr_q.size()), 32'd4);
                for (int i = 0; i < addr_q.size() && i < 4; i++)
                    chk("miss_addr", 32'(addr_q[i]), 32'(cur_base + 24'(i)));
            end
            if (lit_en) begin
                chk("lit_hit", 32'(cur_hit), 32'(lit_hit));
                chk("lit_err", 32'(dut_if.rsp_err), 32'(lit_err));
                if (!lit_err) chk("lit_data", dut_if.rsp_data, lit_data);
                lit_en = 0;
            end
            $display("rsp #%0d base=0x%06h data=0x%08h err=%0d hit=%0d lat=%0d",
                     rsp_cnt, cur_base, dut_if.rsp_data, dut_if.rsp_err, cur_hit, cyc - acc_cyc);
            held = dut_if.rsp_data;
            addr_q.delete();
            busy = 0;
            rsp_cnt++;
        end
        s_rsp_valid = dut_if.rsp_valid;
        s_rsp_err   = dut_if.rsp_err;
        s_cs_prev   = dut_if.fl_chipSel;
        s_addr_prev = dut_if.fl_addr;
    endtask

    task automatic tick();
        pre_edge();
        @(posedge clk);
        #1;
        ctrl_step();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(dut_if.req_ready && !busy) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            tmo_flag = 1;
            tick();
        end
    endtask

    task automatic do_req(input logic [23:0] a, input bit h, input bit e, input logic [31:0] d,
                          input bit inv_lookup, input bit inv_resp);
        int n = 0;
        int start;
        wait_idle();
        lit_en = 1; lit_hit = h; lit_err = e; lit_data = d;
        dut_if.req_valid = 1'b1;
        dut_if.req_addr  = a;
        start = rsp_cnt;
        tick();
        dut_if.req_valid = 1'b0;
        dut_if.req_addr  = 24'($urandom);
        if (inv_lookup) begin
            dut_if.inv = 1'b1;
            tick();
            dut_if.inv = 1'b0;
        end
        while (rsp_cnt == start && n < 500) begin
            tick();
            n++;
        end
        if (rsp_cnt == start) begin
            tmo_flag = 1;
            lit_en = 0;
            tick();
        end else if (inv_resp) begin
            dut_if.inv = 1'b1;
            tick();
            dut_if.inv = 1'b0;
        end
    endtask

    initial begin
        int n;
        dut_if.req_valid = 1'b0;
        dut_if.req_addr  = '0;
        dut_if.inv       = 1'b0;
        dut_if.fl_ready  = 1'b0;
        dut_if.fl_data   = 8'h5A;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        do_req(24'h000102, 0, 0, 32'h44332211, 0, 0);
        do_req(24'h000100, 1, 0, 32'h44332211, 0, 0);
        dut_if.inv = 1'b1; tick(); dut_if.inv = 1'b0;
        do_req(24'h000100, 0, 0, 32'h44332211, 0, 0);
        do_req(24'h000200, 0, 0, 32'h5D5C5F5E, 0, 1);
        do_req(24'h000200, 0, 0, 32'h5D5C5F5E, 0, 0);
        do_req(24'h000201, 1, 0, 32'h5D5C5F5E, 0, 0);
        do_req(24'h000200, 0, 0, 32'h5D5C5F5E, 1, 0);

        stall = 1;
        do_req(24'h000300, 0, 1, 32'h0, 0, 0);
        stall = 0;
        do_req(24'h000300, 0, 0, 32'h5C5D5E5F, 0, 0);

        do_req(24'hFFFFFE, 0, 0, 32'hD4C3B2A1, 0, 0);
        do_req(24'hFFFFFC, 1, 0, 32'hD4C3B2A1, 0, 0);

        // reset while the second byte of a miss is outstanding
        wait_idle();
        dut_if.req_valid = 1'b1;
        dut_if.req_addr  = 24'h000400;
        tick();
        dut_if.req_valid = 1'b0;
        n = 0;
        while (!(dut_if.fl_chipSel && dut_if.fl_addr == 24'h000401) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) tmo_flag = 1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        do_req(24'hFFFFFC, 0, 0, 32'hD4C3B2A1, 0, 0);
        do_req(24'h000400, 0, 0, 32'h5B5A5958, 0, 0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/flash_word_fetcher.md
Name: flash_word_fetcher

Overview:
Upstream master for spi_flash_controller. Accepts 32-bit word read requests from the processor-side bus and issues four sequential single-byte reads to the controller. It assembles the bytes little-endian and returns the word. A one-entry word buffer returns repeat reads of the last word without flash traffic, and a per-byte watchdog flags a controller that never signals ready.

Parameters:
TIMEOUT_CYC, 200, max cycles fl_ready may stay low after a byte read is issued; must exceed one controller byte transaction (about 83 cycles)
BUF_EN, 1, 1 enables the one-entry word buffer; 0 makes every request a miss

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  word read request
req_addr  in  24  byte address; bits [1:0] ignored (word aligned)
req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
inv  in  1  invalidate word buffer
rsp_valid  out  1  one-cycle response strobe
rsp_data  out  32  assembled word, held until next rsp_valid
rsp_err  out  1  qualifies rsp_valid; watchdog expired
fl_chipSel  out  1  to controller chipSel
fl_readMem  out  1  to controller readMem
fl_addr  out  24  to controller addressBus
fl_data  in  8  from controller dataOut
fl_ready  in  1  from controller ready (one-cycle pulse)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All outputs and state are registered.
- Reset values: req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, fl_chipSel=0, fl_readMem=0, fl_addr=0, buffer valid=0, state IDLE.
- FSM states: IDLE, LOOKUP, ISSUE, WAIT, GAP, RESP.
- IDLE: on accept, latch base={req_addr[23:2],2'b00], clear byte index idx, and go to LOOKUP.
- LOOKUP (1 cycle): if BUF_EN, buffer valid, and tag==base[23:2], load rsp_data from buffer and go to RESP (hit latency 2 cycles from accept). Otherwise go to ISSUE.
- ISSUE: drive fl_addr=base+idx and fl_chipSel=fl_readMem=1, clear watchdog, go to WAIT.
- WAIT: hold chipSel, readMem and fl_addr stable; the watchdog increments each cycle.
  - When fl_ready=1, capture fl_data into byte lane idx (idx0→[7:0] … idx3→[31:24]) in that same cycle; fl_data is only valid while chipSel&&readMem are high.
  - At that edge, deassert chipSel/readMem. Then go to GAP if idx<3, or to RESP if idx==3.
- Watchdog: if the counter reaches TIMEOUT_CYC-1 without fl_ready, deassert chipSel/readMem, set rsp_err=1, and go to RESP. The buffer is not updated.
- GAP (1 cycle): chipSel/readMem low so the controller returns to IDLE. Increment idx, then go to ISSUE.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE. On a successful miss, write buffer tag=base[23:2], data=word, valid=1. rsp_err clears on the next cycle.
- inv: clears buffer valid in any state.
  - inv in the same cycle as a RESP buffer write: inv wins, buffer left invalid.
  - inv during LOOKUP: forces a miss.
- req_valid outside IDLE is ignored (req_ready=0); the requester must hold it.
- Address arithmetic: base+idx is 24-bit modulo. Word 0xFFFFFC reads 0xFFFFFC..0xFFFFFF; there is no wrap inside a word because the base is aligned.
- Mid-operation reset: rst in any state returns to reset values next cycle, including dropping fl_chipSel. The controller aborts via its own reset.
- Miss latency: 2 + 4×(controller byte time + 2) cycles.

Decomposition:
- Shared package (flash_pkg): state encodings, FLASH_ADDR_W=24, FLASH_READ_CMD=8'h03, WORD_BYTES=4.
- One natural sub-module, flash_word_buf: tag/valid/data register with lookup, write and inv ports, instantiated only when BUF_EN=1.

Test Plan:
- Miss read: spi_flash_controller plus a behavioural flash model holding 0x11,0x22,0x33,0x44 at 0x000100..103; request 0x000102 → fl_addr sequence 0x100,0x101,0x102,0x103; rsp_data=0x44332211, rsp_err=0, and fl_chipSel low for ≥1 cycle between bytes.
- Hit: repeat request 0x000100 → rsp_valid exactly 2 cycles after accept, no fl_chipSel activity, data 0x44332211.
- Invalidate: inv pulse, then request 0x000100 → full 4-byte flash sequence reissued. Also inv coincident with RESP of a miss → next same-address request misses.
- Timeout: stub fl_ready stuck 0 with TIMEOUT_CYC=20 → rsp_valid with rsp_err=1 at cycle 20 of the first byte, chipSel dropped, later request to the same address misses.
- Top-of-memory: request 0xFFFFFE → addresses 0xFFFFFC..0xFFFFFF, correct little-endian assembly.
- Reset mid-read: assert rst during WAIT of byte 2 → next cycle all outputs at reset values, buffer invalid; a subsequent request completes correctly.
